// File: rtl/display_scheduler_if.sv
// -----------------------------------------------------------------------------
// display_scheduler_if
//   Bundles the source-side inputs and display-side outputs of the
//   display_scheduler. The scheduler connects through the slave modport.
//   The environment or upstream logic that drives the sources and consumes the
//   display path connects through the master modport.
//
//   Enable    scheduler run; low forces IDLE
//   SrcData   source k data at [k*Size +: Size]
//   SrcValid  level, source k has displayable data
//   AlertReq  1-cycle pulse, request alert display of source k
//   AlertAck  1-cycle pulse when alert k is accepted
//   Data      to Data2Segments.Data
//   Blank     display blank request
//   Current   index currently shown
//   Alert     high while an alert is being shown
// -----------------------------------------------------------------------------
interface display_scheduler_if #(
  parameter int N    = 4,
  parameter int Size = 4
);
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  logic              Enable;
  logic [N*Size-1:0] SrcData;
  logic [N-1:0]      SrcValid;
  logic [N-1:0]      AlertReq;
  logic [N-1:0]      AlertAck;
  logic [Size-1:0]   Data;
  logic              Blank;
  logic [CW-1:0]     Current;
  logic              Alert;

  modport master (
    output Enable, SrcData, SrcValid, AlertReq,
    input  AlertAck, Data, Blank, Current, Alert
  );

  modport slave (
    input  Enable, SrcData, SrcValid, AlertReq,
    output AlertAck, Data, Blank, Current, Alert
  );
endinterface

// File: rtl/display_scheduler.sv
// -----------------------------------------------------------------------------
// display_scheduler
//   Shares one 7-segment display path among N data sources. It round-robins
//   over the valid sources with a fixed dwell time per source. One-shot alert
//   requests pre-empt the rotation and show the requested source for a fixed
//   alert time. Pending alerts are served lowest index first, back to back.
//
//   Optional feature: define DISPLAY_BLINK_EN to make Blank toggle every
//   BlinkCycles cycles while an alert is shown. The toggling starts unblanked.
//   In the default build Blank stays low for the whole alert.
//
// Ports
//   Clock    system clock, all logic on posedge
//   nReset   asynchronous, active-low reset
//   bus      display_scheduler_if.slave
//            inputs:  Enable, SrcData, SrcValid, AlertReq
//            outputs: AlertAck, Data, Blank, Current, Alert (all registered)
// -----------------------------------------------------------------------------
module display_scheduler #(
  parameter int N              = 4,
  parameter int Size           = 4,
  parameter int ClockPeriod_ns = 20,
  parameter int DwellTime_ns   = 1_000_000_000,
  parameter int AlertTime_ns   = 500_000_000,
  parameter int BlinkTime_ns   = 100_000_000
) (
  input logic                Clock,
  input logic                nReset,
  display_scheduler_if.slave bus
);
  localparam int CW          = (N > 1) ? $clog2(N) : 1;
  localparam int DwellCycles = DwellTime_ns / ClockPeriod_ns;
  localparam int AlertCycles = AlertTime_ns / ClockPeriod_ns;
  localparam int BlinkCycles = BlinkTime_ns / ClockPeriod_ns;
  localparam int MaxDA       = (DwellCycles > AlertCycles) ? DwellCycles : AlertCycles;
  localparam int MaxCycles   = (MaxDA > BlinkCycles) ? MaxDA : BlinkCycles;
  // One timer width covers every interval the block can be configured to count.
  localparam int TW          = $clog2(MaxCycles + 1);

  localparam logic [TW-1:0] DwellLast = TW'(DwellCycles - 1);
  localparam logic [TW-1:0] AlertLast = TW'(AlertCycles - 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHOW  = 2'd1;
  localparam logic [1:0] ALERT = 2'd2;

  // First set bit of v strictly after index s, wrapping N-1 -> 0.
  // The bit at s itself is checked last, so a lone valid source is picked again.
  // Starting from s = N-1 returns the lowest set index.
  function automatic logic [CW-1:0] rr_pick(input logic [N-1:0] v,
                                            input logic [CW-1:0] s);
    logic [CW-1:0] ix;
    rr_pick = s;
    for (int off = N; off >= 1; off--) begin
      ix = CW'((int'(s) + off) % N);
      if (v[ix]) rr_pick = ix;
    end
  endfunction

  logic [1:0]      state, state_n;
  logic [CW-1:0]   cur, cur_n;
  logic [TW-1:0]   cnt, cnt_n;
  logic [N-1:0]    pending, pending_n;
  logic [N-1:0]    ack, grant;
  logic [Size-1:0] data;
  logic            blank, blank_n;
  logic            alert;
  logic [CW-1:0]   alert_pick, rot_pick, low_valid;
  logic            any_valid;
  logic [Size-1:0] src [N];

`ifdef DISPLAY_BLINK_EN
  localparam logic [TW-1:0] BlinkLast = TW'(BlinkCycles - 1);
  logic [TW-1:0] bcnt, bcnt_n;
`endif

  for (genvar k = 0; k < N; k++) begin : g_src
    assign src[k] = bus.SrcData[k*Size +: Size];
  end

  always_comb begin
    state_n    = state;
    cur_n      = cur;
    cnt_n      = cnt;
    grant      = '0;
    any_valid  = |bus.SrcValid;
    alert_pick = rr_pick(pending, CW'(N - 1));
    low_valid  = rr_pick(bus.SrcValid, CW'(N - 1));
    rot_pick   = rr_pick(bus.SrcValid, cur);
    if (!bus.Enable) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else if (|pending && (state != ALERT || cnt == AlertLast)) begin
      // Alerts pre-empt IDLE/SHOW at once, but only follow an alert once it has run its full time.
      state_n           = ALERT;
      cur_n             = alert_pick;
      cnt_n             = '0;
      grant[alert_pick] = 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (any_valid) begin
            state_n = SHOW;
            cur_n   = low_valid;
            cnt_n   = '0;
          end
        end
        SHOW: begin
          if (cnt == DwellLast || !bus.SrcValid[cur]) begin
            cnt_n = '0;
            if (any_valid) cur_n = rot_pick;
            else           state_n = IDLE;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        ALERT: begin
          if (cnt == AlertLast) begin
            cnt_n = '0;
            if (any_valid) begin
              state_n = SHOW;
              cur_n   = rot_pick;
            end else begin
              state_n = IDLE;
            end
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: begin
          state_n = IDLE;
          cnt_n   = '0;
        end
      endcase
    end
  end

  // A request that lands while its own ack is out is the same event and is dropped.
  // This also applies to a request that lands on the grant edge.
  always_comb begin
    pending_n = (pending | (bus.AlertReq & ~ack)) & ~grant;
  end

  always_comb begin
    blank_n = (state_n == IDLE);
`ifdef DISPLAY_BLINK_EN
    bcnt_n = '0;
    // Only an alert that continues blinks; every alert entry restarts unblanked.
    if (state_n == ALERT && grant == '0) begin
      if (bcnt == BlinkLast) begin
        blank_n = ~blank;
      end else begin
        bcnt_n  = bcnt + 1'b1;
        blank_n = blank;
      end
    end
`endif
  end

  always_ff @(posedge Clock or negedge nReset) begin
    if (!nReset) begin
      state   <= IDLE;
      cur     <= '0;
      cnt     <= '0;
      pending <= '0;
      ack     <= '0;
      data    <= '0;
      blank   <= 1'b1;
      alert   <= 1'b0;
`ifdef DISPLAY_BLINK_EN
      bcnt    <= '0;
`endif
    end else begin
      state   <= state_n;
      cur     <= cur_n;
      cnt     <= cnt_n;
      pending <= pending_n;
      ack     <= grant;
      blank   <= blank_n;
      alert   <= (state_n == ALERT);
      // Data is sampled from the source selected for the coming cycle.
      // This keeps Data aligned with Current. IDLE holds the last shown value.
      if (state_n != IDLE) data <= src[cur_n];
`ifdef DISPLAY_BLINK_EN
      bcnt    <= bcnt_n;
`endif
    end
  end

  assign bus.AlertAck = ack;
  assign bus.Data     = data;
  assign bus.Blank    = blank;
  assign bus.Current  = cur;
  assign bus.Alert    = alert;
endmodule
